pll_clk_monitor: RTL and testbench

Lock-qualified, multi-channel clock-divider and health monitor that runs in the PLL output clock domain. It synchronizes the raw PLL lock flag and debounces it into a clean `clk_ready`. It generates `NUM_CH` runtime-programmable divided clocks for pin probing or slow strobes, counts lock-loss events, and drives a heartbeat LED. It sits directly after the `pll_clk` wrapper and replaces ad-hoc /2 toggles and raw-lock LEDs in debug tops.

---
 rtl/pll_clk_monitor.sv | 130 +++++++++++++
 tb/tb_pll_clk_monitor.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pll_clk_monitor.sv
// Lock-qualified clock monitor: synchronizes and debounces PLL lock, runs NUM_CH divided clocks, counts lock losses.
// Optional build macro PLL_MON_HEARTBEAT_EN adds a blinking heartbeat counter; otherwise heartbeat mirrors clk_ready.
module pll_clk_monitor #(
  parameter int NUM_CH        = 4,
  parameter int DIV_W         = 8,
  parameter int STABLE_CYCLES = 1024,
  parameter int LOSS_W        = 8,
  parameter int HB_W          = 24
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    pll_lock,
  input  logic [NUM_CH*DIV_W-1:0] div_half,
  input  logic [NUM_CH-1:0]       ch_en,
  output logic                    clk_ready,
  output logic [NUM_CH-1:0]       div_out,
  output logic [LOSS_W-1:0]       lock_loss_cnt,
  output logic                    heartbeat
);

  localparam int SET_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [SET_W-1:0] SET_MAX = SET_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {ST_UNLOCKED, ST_SETTLE, ST_READY} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [1:0]          r_sync;
  logic                w_lock_s;
  logic [SET_W-1:0]    r_settle;
  logic                r_clk_ready;
  logic [LOSS_W-1:0]   r_loss;
  logic                w_ready_nxt;
  logic                w_loss_evt;
  logic                w_run_ok;
  logic [NUM_CH-1:0]   r_div;

  assign w_lock_s = r_sync[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync   <= 2'b00;
      r_state  <= ST_UNLOCKED;
      r_settle <= '0;
    end else begin
      r_sync  <= {r_sync[0], pll_lock};
      r_state <= w_state_nxt;
      if (r_state != ST_SETTLE)
        r_settle <= '0;
      else if (r_settle != SET_MAX)
        r_settle <= r_settle + SET_W'(1);
    end
  end

  // A lock drop is checked first so it always beats settle completion.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_UNLOCKED: if (w_lock_s) w_state_nxt = ST_SETTLE;
      ST_SETTLE: begin
        if (!w_lock_s)
          w_state_nxt = ST_UNLOCKED;
        else if (r_settle == SET_MAX)
          w_state_nxt = ST_READY;
      end
      ST_READY: if (!w_lock_s) w_state_nxt = ST_UNLOCKED;
      default: w_state_nxt = ST_UNLOCKED;
    endcase
  end

  always_comb begin
    w_ready_nxt = (w_state_nxt == ST_READY);
    w_loss_evt  = (r_state == ST_READY) && (w_state_nxt == ST_UNLOCKED);
    w_run_ok    = (r_state == ST_READY) && (w_state_nxt == ST_READY);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_ready <= 1'b0;
      r_loss      <= '0;
    end else begin
      r_clk_ready <= w_ready_nxt;
      if (w_loss_evt && (r_loss != {LOSS_W{1'b1}}))
        r_loss <= r_loss + LOSS_W'(1);
    end
  end

  // The >= compare lets a shrinking half-period take effect on the very next edge.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [DIV_W-1:0] r_cnt;
    logic             w_run;
    assign w_run = w_run_ok && ch_en[g];
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_cnt    <= '0;
        r_div[g] <= 1'b0;
      end else if (!w_run) begin
        r_cnt    <= '0;
        r_div[g] <= 1'b0;
      end else if (r_cnt >= div_half[g*DIV_W +: DIV_W]) begin
        r_cnt    <= '0;
        r_div[g] <= ~r_div[g];
      end else begin
        r_cnt <= r_cnt + DIV_W'(1);
      end
    end
  end

`ifdef PLL_MON_HEARTBEAT_EN
  logic [HB_W-1:0] r_hb;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_hb <= '0;
    else if (r_clk_ready)
      r_hb <= r_hb + HB_W'(1);
    else
      r_hb <= '0;
  end
  assign heartbeat = r_hb[HB_W-1];
`else
  logic [HB_W-1:0] w_hb_solid;
  assign w_hb_solid = {HB_W{r_clk_ready}};
  assign heartbeat  = w_hb_solid[HB_W-1];
`endif

  assign clk_ready     = r_clk_ready;
  assign div_out       = r_div;
  assign lock_loss_cnt = r_loss;

endmodule

// File: tb/tb_pll_clk_monitor.sv
// Directed plus randomized bench for pll_clk_monitor against a streak/phase-arithmetic reference model.
module tb_pll_clk_monitor;
  localparam int NUM_CH = 4;
  localparam int DIV_W  = 8;
  localparam int STABLE = 16;
  localparam int LOSS_W = 2;
  localparam int HB_W   = 4;

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic                    pll_lock;
  logic [NUM_CH*DIV_W-1:0] div_half;
  logic [NUM_CH-1:0]       ch_en;
  logic                    clk_ready;
  logic [NUM_CH-1:0]       div_out;
  logic [LOSS_W-1:0]       lock_loss_cnt;
  logic                    heartbeat;

  pll_clk_monitor #(
    .NUM_CH(NUM_CH), .DIV_W(DIV_W), .STABLE_CYCLES(STABLE), .LOSS_W(LOSS_W), .HB_W(HB_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pll_lock(pll_lock), .div_half(div_half), .ch_en(ch_en),
    .clk_ready(clk_ready), .div_out(div_out), .lock_loss_cnt(lock_loss_cnt), .heartbeat(heartbeat)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errs    = 0;

  // Reference model: lock streaks, ready history, per-channel running-edge counts.
  int raw, d1, d2;
  bit rdy;
  int loss;
  int hb;
  int n   [NUM_CH];
  bit base[NUM_CH];
  bit dv  [NUM_CH];
  bit rebase0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    raw = 0; d1 = 0; d2 = 0; rdy = 0; loss = 0; hb = 0; rebase0 = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      n[i] = 0; base[i] = 0; dv[i] = 0;
    end
  endtask

  task automatic tick();
    bit rdy_new;
    bit run;
    int h;
    logic [NUM_CH-1:0] exp_div;
    @(posedge clk);
    d2 = d1;
    d1 = raw;
    raw = pll_lock ? ((raw < 100000) ? raw + 1 : raw) : 0;
    rdy_new = (d2 >= STABLE + 1);
    if (rdy && !rdy_new && loss < 3) loss++;
    hb = rdy ? (hb + 1) % (1 << HB_W) : 0;
    for (int i = 0; i < NUM_CH; i++) begin
      h = int'(div_half[i*DIV_W +: DIV_W]);
      run = rdy && rdy_new && ch_en[i];
      if (!run) begin
        n[i] = 0; base[i] = 0; dv[i] = 0;
      end else if (i == 0 && rebase0) begin
        dv[i] = !dv[i]; base[i] = dv[i]; n[i] = 0; rebase0 = 0;
      end else begin
        n[i]++;
        dv[i] = base[i] ^ bit'((n[i] / (h + 1)) % 2);
      end
      exp_div[i] = dv[i];
    end
    rdy = rdy_new;
    #1;
    chk("clk_ready", 32'(clk_ready), 32'(rdy));
    chk("div_out", 32'(div_out), 32'(exp_div));
    chk("lock_loss_cnt", 32'(lock_loss_cnt), 32'(loss));
`ifdef PLL_MON_HEARTBEAT_EN
    chk("heartbeat", 32'(heartbeat), 32'((hb >> (HB_W - 1)) & 1));
`else
    chk("heartbeat", 32'(heartbeat), 32'(rdy));
`endif
  endtask

  initial begin
    int rise;
    int r1[NUM_CH];
    int r2[NUM_CH];
    logic [NUM_CH-1:0] prev;
    logic p0;
    int k;
    int tot;

    reset_n = 1'b0; pll_lock = 1'b0; ch_en = '0; div_half = '0;
    model_reset();
    #1;
    chk("rst_clk_ready", 32'(clk_ready), 0);
    chk("rst_div_out", 32'(div_out), 0);
    chk("rst_loss", 32'(lock_loss_cnt), 0);
    chk("rst_heartbeat", 32'(heartbeat), 0);
    #11 reset_n = 1'b1;

    // Lock glitch: 10 high, 5 low, then steady high.
    repeat (2) tick();
    pll_lock = 1'b1; repeat (10) tick();
    pll_lock = 1'b0; repeat (5) tick();
    pll_lock = 1'b1;
    rise = -1;
    for (int e = 1; e <= 40; e++) begin
      tick();
      if (clk_ready && rise < 0) rise = e;
    end
    chk("ready_edge_after_glitch", rise, STABLE + 3);
    chk("loss_after_glitch", 32'(lock_loss_cnt), 0);

    // Four channels, half-periods 0..3.
    ch_en = 4'hF;
    div_half = {8'd3, 8'd2, 8'd1, 8'd0};
    for (int i = 0; i < NUM_CH; i++) begin r1[i] = -1; r2[i] = -1; end
    prev = div_out;
    for (int e = 1; e <= 40; e++) begin
      tick();
      for (int i = 0; i < NUM_CH; i++) begin
        if (!prev[i] && div_out[i]) begin
          if (r1[i] < 0) r1[i] = e; else if (r2[i] < 0) r2[i] = e;
        end
      end
      prev = div_out;
    end
    for (int i = 0; i < NUM_CH; i++) chk("div_period", r2[i] - r1[i], 2 * (i + 1));

    // Lock drop from READY.
    pll_lock = 1'b0;
    repeat (3) tick();
    chk("drop_clk_ready", 32'(clk_ready), 0);
    chk("drop_div_out", 32'(div_out), 0);
    chk("drop_loss", 32'(lock_loss_cnt), 1);

    // Half-period shrink mid-count on channel 0.
    div_half = {8'd3, 8'd2, 8'd1, 8'd200};
    pll_lock = 1'b1;
    repeat (19) tick();
    k = 0;
    while (n[0] < 100 && k < 300) begin tick(); k++; end
    chk("ch0_reached_mid_count", n[0], 100);
    div_half[7:0] = 8'd5;
    rebase0 = 1;
    p0 = div_out[0];
    tick();
    chk("shrink_toggle_next_edge", 32'(div_out[0]), 32'(!p0));
    tot = 0;
    for (int t = 0; t < 2; t++) begin
      p0 = div_out[0];
      k = 0;
      while (div_out[0] == p0 && k < 30) begin tick(); k++; end
      tot += k;
    end
    chk("shrunk_period", tot, 12);
    ch_en[0] = 1'b0;
    tick();
    chk("ch0_disable", 32'(div_out[0]), 0);

    // Five more lock losses saturate the 2-bit counter.
    for (int t = 0; t < 5; t++) begin
      pll_lock = 1'b0; repeat (4) tick();
      pll_lock = 1'b1; repeat (20) tick();
    end
    chk("loss_saturated", 32'(lock_loss_cnt), 3);

    // Randomized enables, half-periods and lock toggles.
    for (int it = 0; it < 600; it++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if ($urandom % 20 == 0) begin
          if (ch_en[i]) ch_en[i] = 1'b0;
          else begin
            div_half[i*DIV_W +: DIV_W] = DIV_W'($urandom % 8);
            ch_en[i] = 1'b1;
          end
        end
      end
      if ($urandom % 60 == 0) pll_lock = !pll_lock;
      tick();
    end

    // Asynchronous reset mid-run, then re-lock.
    pll_lock = 1'b1;
    repeat (25) tick();
    ch_en = 4'hF;
    repeat (10) tick();
    #2 reset_n = 1'b0;
    #1;
    chk("arst_clk_ready", 32'(clk_ready), 0);
    chk("arst_div_out", 32'(div_out), 0);
    chk("arst_loss", 32'(lock_loss_cnt), 0);
    chk("arst_heartbeat", 32'(heartbeat), 0);
    model_reset();
    #2 reset_n = 1'b1;
    rise = -1;
    for (int e = 1; e <= 40; e++) begin
      tick();
      if (clk_ready && rise < 0) rise = e;
    end
    chk("ready_edge_after_reset", rise, STABLE + 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
